// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encoding, FSM states
// and bit positions inside the 4-bit {N,V,Z,C} flags word.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_NOP   = 4'd0,
        OP_ADD   = 4'd1,
        OP_SUB   = 4'd2,
        OP_RSUB  = 4'd3,
        OP_AND   = 4'd4,
        OP_OR    = 4'd5,
        OP_XOR   = 4'd6,
        OP_PASSA = 4'd7,
        OP_PASSB = 4'd8,
        OP_SHL   = 4'd9,
        OP_SHR   = 4'd10,
        OP_ASR   = 4'd11,
        OP_MUL   = 4'd12
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Flag word layout is {N,V,Z,C}; N is always the MSB of the full result
    // (for MUL that is the top bit of the 2*WIDTH-bit product).
    localparam int FLAG_C = 0;
    localparam int FLAG_Z = 1;
    localparam int FLAG_V = 2;
    localparam int FLAG_N = 3;

endpackage

// File: rtl/alu_mul_seq.sv
// Unsigned shift-add multiplier: one partial product per clock, WIDTH steps
// after a start pulse. done is high whenever no iteration is pending.
module alu_mul_seq #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CW-1:0]      count;

    // Load operands on start, then add the shifted multiplicand for each set multiplier bit.
    always_ff @(posedge clk or negedge reset_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!reset_n) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (start) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
            count  <= CW'(WIDTH);
        end else if (count != '0) begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count - CW'(1);
        end
    end

    assign done    = (count == '0);
    assign product = acc;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes. Single-cycle ops complete on
// the edge after accept; MUL runs through alu_mul_seq and takes WIDTH+1 cycles.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int MUL_EN = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out,
    output logic [WIDTH-1:0] out_hi,
    output logic [3:0]       flags
);

    localparam int CW = $clog2(WIDTH + 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               accept;
    logic               is_mul;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH-1:0]   amt;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff_ab;
    logic [WIDTH:0]     diff_ba;
    logic [WIDTH:0]     res;
    logic [WIDTH:0]     wide;
    logic               v_bit;
    logic               known;
    logic [3:0]         alu_flags;

    // In-ready is held low while reset is asserted so nothing is accepted until release.
    assign in_ready = reset_n & ((state == ST_IDLE) | ((state == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;
    assign is_mul   = (MUL_EN != 0) && (opcode == OP_MUL);

    assign amt     = in2 % WIDTH'(WIDTH);
    assign sum     = {1'b0, in1} + {1'b0, in2};
    assign diff_ab = {1'b0, in1} - {1'b0, in2};
    assign diff_ba = {1'b0, in2} - {1'b0, in1};

    // Single-cycle datapath: result bit WIDTH carries carry, borrow or last shifted-out bit.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the case infers a latch.
        res       = '0;
        wide      = '0;
        v_bit     = 1'b0;
        known     = 1'b1;
        alu_flags = '0;
        case (opcode_t'(opcode))
            OP_ADD: begin
                res   = sum;
                v_bit = (in1[WIDTH-1] == in2[WIDTH-1]) && (sum[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_SUB: begin
                res   = diff_ab;
                v_bit = (in1[WIDTH-1] != in2[WIDTH-1]) && (diff_ab[WIDTH-1] != in1[WIDTH-1]);
            end
            OP_RSUB: begin
                res   = diff_ba;
                v_bit = (in2[WIDTH-1] != in1[WIDTH-1]) && (diff_ba[WIDTH-1] != in2[WIDTH-1]);
            end
            OP_AND:   res = {1'b0, in1 & in2};
            OP_OR:    res = {1'b0, in1 | in2};
            OP_XOR:   res = {1'b0, in1 ^ in2};
            OP_PASSA: res = {1'b0, in1};
            OP_PASSB: res = {1'b0, in2};
            OP_SHL:   res = {1'b0, in1} << amt;
            OP_SHR: begin
                wide = {in1, 1'b0} >> amt;
                res  = {wide[0], wide[WIDTH:1]};
            end
            OP_ASR: begin
                wide = $signed({in1, 1'b0}) >>> amt;
                res  = {wide[0], wide[WIDTH:1]};
            end
            default: known = 1'b0;
        endcase
        if (known) begin
            alu_flags[FLAG_N] = res[WIDTH-1];
            alu_flags[FLAG_V] = v_bit;
            alu_flags[FLAG_Z] = (res[WIDTH-1:0] == '0);
            alu_flags[FLAG_C] = res[WIDTH];
        end
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (accept & is_mul),
        .a       (in1),
        .b       (in2),
        .done    (mul_done),
        .product (mul_prod)
    );

    // Control FSM with registered result, flags and out_valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            out_valid <= 1'b0;
            out       <= '0;
            out_hi    <= '0;
            flags     <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state     <= ST_BUSY;
                            cnt       <= CW'(WIDTH);
                            out_valid <= 1'b0;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                            out       <= res;
                            out_hi    <= '0;
                            flags     <= alu_flags;
                        end
                    end else if ((state == ST_DONE) && out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                    end
                end
                ST_BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (mul_done) begin
                        state         <= ST_DONE;
                        out_valid     <= 1'b1;
                        out           <= {1'b0, mul_prod[WIDTH-1:0]};
                        out_hi        <= mul_prod[2*WIDTH-1:WIDTH];
                        flags         <= '0;
                        flags[FLAG_N] <= mul_prod[2*WIDTH-1];
                        flags[FLAG_Z] <= (mul_prod == '0);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
